// File: rtl/task_pkg.sv
// Shared constants for the task sequencer: state encoding, default sizes, channel map.
package task_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_TRIG = 2'b01;
    localparam logic [1:0] ST_BUSY = 2'b10;

    localparam int unsigned N_CH_DEF  = 2;
    localparam int unsigned REP_W_DEF = 8;
    localparam int unsigned TO_W_DEF  = 16;

    localparam int unsigned CH_ADC = 0;
    localparam int unsigned CH_DAC = 1;

endpackage

// File: rtl/task_timer.sv
// Per-repetition watchdog: counts enabled cycles and flags the cycle that reaches the limit.
module task_timer
    import task_pkg::*;
#(
    parameter int unsigned TO_W = TO_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_en,
    input  logic [TO_W-1:0] i_limit,
    output logic            o_expire_c
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    // A zero limit disables expiry; otherwise fire on the limit-th enabled cycle.
    assign o_expire_c = i_en && (i_limit != '0) && (r_cnt == i_limit - TO_W'(1));

endmodule

// File: rtl/task_sequencer.sv
// Dispatches a repeated trigger/wait task to one of N_CH conversion engines,
// with per-repetition timeout, abort and single-cycle status pulses.
module task_sequencer
    import task_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned SEL_W = $clog2(N_CH),
    parameter int unsigned REP_W = REP_W_DEF,
    parameter int unsigned TO_W  = TO_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger_task,
    input  logic [SEL_W-1:0] sel,
    input  logic [REP_W-1:0] rep_num,
    input  logic [TO_W-1:0]  timeout_cyc,
    input  logic             abort,
    input  logic [N_CH-1:0]  done_ch,
    output logic [N_CH-1:0]  trigger_ch,
    output logic             done_task,
    output logic             timeout_err,
    output logic             cfg_err,
    output logic             busy,
    output logic [REP_W-1:0] rep_idx
);

    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_sel;
    logic [REP_W-1:0] r_rep_num;
    logic [TO_W-1:0]  r_timeout;
    logic [REP_W-1:0] r_rep_idx;
    logic [N_CH-1:0]  r_trig;
    logic             r_done;
    logic             r_to_err;
    logic             r_cfg_err;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [REP_W-1:0] w_rep_num_nxt;
    logic [TO_W-1:0]  w_timeout_nxt;
    logic [REP_W-1:0] w_rep_idx_nxt;
    logic [N_CH-1:0]  w_trig_nxt;
    logic             w_done_nxt;
    logic             w_to_err_nxt;
    logic             w_cfg_err_nxt;
    logic             w_done_sel;
    logic             w_expire;

    task_timer #(.TO_W(TO_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (r_state == ST_TRIG),
        .i_en       (r_state == ST_BUSY),
        .i_limit    (r_timeout),
        .o_expire_c (w_expire)
    );

    assign w_done_sel = done_ch[r_sel];

    // Next-state and next-output logic; abort overrides everything outside IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_rep_num_nxt = r_rep_num;
        w_timeout_nxt = r_timeout;
        w_rep_idx_nxt = r_rep_idx;
        w_trig_nxt    = '0;
        w_done_nxt    = 1'b0;
        w_to_err_nxt  = 1'b0;
        w_cfg_err_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (trigger_task) begin
                    if (32'(sel) < N_CH) begin
                        w_sel_nxt     = sel;
                        w_rep_num_nxt = (rep_num == '0) ? REP_W'(1) : rep_num;
                        w_timeout_nxt = timeout_cyc;
                        w_rep_idx_nxt = '0;
                        w_trig_nxt    = N_CH'(1) << sel;
                        w_state_nxt   = ST_TRIG;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
            end
            ST_TRIG: begin
                w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_done_sel) begin
                    if (r_rep_idx + REP_W'(1) < r_rep_num) begin
                        w_rep_idx_nxt = r_rep_idx + REP_W'(1);
                        w_trig_nxt    = N_CH'(1) << r_sel;
                        w_state_nxt   = ST_TRIG;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_expire) begin
                    w_to_err_nxt = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt   = ST_IDLE;
            w_rep_idx_nxt = r_rep_idx;
            w_trig_nxt    = '0;
            w_done_nxt    = 1'b0;
            w_to_err_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_rep_num <= '0;
            r_timeout <= '0;
            r_rep_idx <= '0;
            r_trig    <= '0;
            r_done    <= 1'b0;
            r_to_err  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_rep_num <= w_rep_num_nxt;
            r_timeout <= w_timeout_nxt;
            r_rep_idx <= w_rep_idx_nxt;
            r_trig    <= w_trig_nxt;
            r_done    <= w_done_nxt;
            r_to_err  <= w_to_err_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign trigger_ch  = r_trig;
    assign done_task   = r_done;
    assign timeout_err = r_to_err;
    assign cfg_err     = r_cfg_err;
    assign busy        = r_busy;
    assign rep_idx     = r_rep_idx;

endmodule
